bfly2_stage: RTL

BFLY2_STAGE -- requirements
Module: bfly2_stage

---
 rtl/bfly2_stage_if.sv | 24 ++
 rtl/bfly2_stage.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/bfly2_stage_if.sv
// Streaming handshake bundle for the radix-2 butterfly stage.
// slave is the block's own view; master is the view of whatever drives and consumes it.
interface bfly2_stage_if #(
  parameter int DW = 32
);
  logic          valid_i;
  logic [DW-1:0] data_i;
  logic          ready_o;
  logic          valid_o;
  logic [DW-1:0] data_o;
  logic          ready_i;
  logic          last_o;
  logic          ovf_o;

  modport slave (
    input  valid_i, data_i, ready_i,
    output ready_o, valid_o, data_o, last_o, ovf_o
  );

  modport master (
    output valid_i, data_i, ready_i,
    input  ready_o, valid_o, data_o, last_o, ovf_o
  );
endinterface

// File: rtl/bfly2_stage.sv
// Radix-2 butterfly stage: pairs consecutive samples (a, b) and emits a+b then a-b per complex part.
// Optional macro BFLY2_SCALE_EN: halve each result instead of saturating it (ovf_o then never sets).
module bfly2_stage #(
  parameter int K  = 10,
  parameter int DW = 32
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  bfly2_stage_if.slave bus
);
  localparam int W  = DW / 2;
  localparam int CW = (K > 1) ? K - 1 : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'((1 << (K - 1)) - 1);

  typedef enum logic {S_A = 1'b0, S_B = 1'b1} state_t;
  state_t state_q, state_d;

  logic          run_q;
  logic          valid_q, last_q, ovf_q;
  logic [DW-1:0] data_q;
  logic [CW-1:0] pair_cnt_q;
  logic          ready, a_xfer, b_xfer, out_xfer;

  logic [DW-1:0] a_p0;
  logic [DW-1:0] diff_p1;
  logic          diff_pend_p1, diff_last_p1;

  logic signed [W-1:0] a_re, a_im, b_re, b_im;
  logic signed [W:0]   sum_re, sum_im, dif_re, dif_im;
  logic [DW-1:0]       sum_w, dif_w;
  logic                clip_any;

`ifdef BFLY2_SCALE_EN
  function automatic logic [W-1:0] fit(input logic signed [W:0] x);
    fit = W'(x >>> 1);
  endfunction
`else
  // Top two bits disagree exactly when the W+1-bit value is outside the W-bit range.
  function automatic logic clip(input logic signed [W:0] x);
    clip = x[W] ^ x[W-1];
  endfunction

  function automatic logic [W-1:0] fit(input logic signed [W:0] x);
    if (clip(x)) fit = x[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    else         fit = x[W-1:0];
  endfunction
`endif

  assign a_re = a_p0[W-1:0];
  assign a_im = a_p0[DW-1:W];
  assign b_re = bus.data_i[W-1:0];
  assign b_im = bus.data_i[DW-1:W];

  assign sum_re = (W+1)'(a_re) + (W+1)'(b_re);
  assign sum_im = (W+1)'(a_im) + (W+1)'(b_im);
  assign dif_re = (W+1)'(a_re) - (W+1)'(b_re);
  assign dif_im = (W+1)'(a_im) - (W+1)'(b_im);

  assign sum_w = {fit(sum_im), fit(sum_re)};
  assign dif_w = {fit(dif_im), fit(dif_re)};

`ifdef BFLY2_SCALE_EN
  assign clip_any = 1'b0;
`else
  assign clip_any = clip(sum_re) | clip(sum_im) | clip(dif_re) | clip(dif_im);
`endif

  // run_q keeps ready_o low until the first edge after reset release.
  always_comb begin
    state_d = state_q;
    ready   = 1'b0;
    if (run_q) begin
      case (state_q)
        S_A: begin
          ready = 1'b1;
          if (bus.valid_i) state_d = S_B;
        end
        S_B: begin
          ready = !diff_pend_p1 && (!valid_q || bus.ready_i);
          if (bus.valid_i && ready) state_d = S_A;
        end
        default: state_d = S_A;
      endcase
    end
  end

  assign a_xfer   = bus.valid_i && ready && (state_q == S_A);
  assign b_xfer   = bus.valid_i && ready && (state_q == S_B);
  assign out_xfer = valid_q && bus.ready_i;

  // p0: hold the even sample until its partner arrives
  always_ff @(posedge clk_i) begin
    if (a_xfer) a_p0 <= bus.data_i;
  end

  // p1: diff waits here while sum occupies the output register
  always_ff @(posedge clk_i) begin
    if (b_xfer) begin
      diff_p1      <= dif_w;
      diff_last_p1 <= (pair_cnt_q == CNT_MAX);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= S_A;
      run_q        <= 1'b0;
      valid_q      <= 1'b0;
      last_q       <= 1'b0;
      ovf_q        <= 1'b0;
      data_q       <= '0;
      diff_pend_p1 <= 1'b0;
      pair_cnt_q   <= '0;
    end else begin
      run_q   <= 1'b1;
      state_q <= state_d;
      if (b_xfer) begin
        valid_q      <= 1'b1;
        data_q       <= sum_w;
        last_q       <= 1'b0;
        diff_pend_p1 <= 1'b1;
        ovf_q        <= ovf_q | clip_any;
        pair_cnt_q   <= (pair_cnt_q == CNT_MAX) ? '0 : pair_cnt_q + 1'b1;
      end else if (out_xfer) begin
        if (diff_pend_p1) begin
          data_q       <= diff_p1;
          last_q       <= diff_last_p1;
          diff_pend_p1 <= 1'b0;
        end else begin
          valid_q <= 1'b0;
          last_q  <= 1'b0;
        end
      end
    end
  end

  assign bus.ready_o = ready;
  assign bus.valid_o = valid_q;
  assign bus.data_o  = data_q;
  assign bus.last_o  = last_q;
  assign bus.ovf_o   = ovf_q;
endmodule
